noc_xy_router: RTL and testbench

- Parametrised five-port 2D-mesh router, successor to the single-hop per-PE router.
- Adds per-input buffering, deterministic XY dimension-order routing from flit header coordinates, per-output round-robin arbitration and valid/ready backpressure on every port.
- One instance per PE tile. The mesh top stitches N/E/S/W ports of neighbours together. The Local port connects to the PE.

---
 rtl/noc_pkg.sv | 46 ++++
 rtl/noc_xy_router_if.sv | 30 +++
 rtl/noc_sync_fifo.sv | 56 +++++
 rtl/noc_xy_router.sv | 132 +++++++++++++
 tb/tb_noc_xy_router.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the XY mesh router: port indices, flit field offsets
// and the dimension-order route / round-robin helper functions.
package noc_pkg;

  localparam int NUM_PORTS = 5;
  localparam int PORT_L    = 0;
  localparam int PORT_N    = 1;
  localparam int PORT_E    = 2;
  localparam int PORT_S    = 3;
  localparam int PORT_W    = 4;

  // Coordinates are zero-extended to this width before routing comparisons.
  localparam int COORD_MAX_W = 8;

  typedef logic [2:0] port_t;

  // Flit layout is {dest_y, dest_x, payload}, payload in the low bits.
  function automatic int payload_lsb();
    return 0;
  endfunction

  function automatic int dest_x_lsb(input int data_width);
    return data_width;
  endfunction

  function automatic int dest_y_lsb(input int data_width, input int coord_w);
    return data_width + coord_w;
  endfunction

  // X is resolved before Y; equal coordinates in both dimensions mean Local.
  function automatic port_t xy_route(input logic [COORD_MAX_W-1:0] dest_x,
                                     input logic [COORD_MAX_W-1:0] dest_y,
                                     input logic [COORD_MAX_W-1:0] my_x,
                                     input logic [COORD_MAX_W-1:0] my_y);
    if (dest_x > my_x)      return port_t'(PORT_E);
    else if (dest_x < my_x) return port_t'(PORT_W);
    else if (dest_y > my_y) return port_t'(PORT_S);
    else if (dest_y < my_y) return port_t'(PORT_N);
    else                    return port_t'(PORT_L);
  endfunction

  function automatic port_t rr_next(input port_t idx);
    return (idx == port_t'(NUM_PORTS - 1)) ? port_t'(0) : port_t'(idx + port_t'(1));
  endfunction

endpackage

// File: rtl/noc_xy_router_if.sv
// Bundled five-port flit bus of one router: input side, output side and the
// per-output forwarded-flit counters. Slice p of each vector belongs to port p.
interface noc_xy_router_if #(
  parameter int DATA_WIDTH = 32,
  parameter int COORD_W    = 3
);
  import noc_pkg::*;

  localparam int FLIT_W = DATA_WIDTH + 2 * COORD_W;

  logic [NUM_PORTS*FLIT_W-1:0] in_flit;
  logic [NUM_PORTS-1:0]        in_valid;
  logic [NUM_PORTS-1:0]        in_ready;
  logic [NUM_PORTS*FLIT_W-1:0] out_flit;
  logic [NUM_PORTS-1:0]        out_valid;
  logic [NUM_PORTS-1:0]        out_ready;
  logic [NUM_PORTS*16-1:0]     stat_flits;

  // master = neighbours/PE driving the router, slave = the router itself
  modport master (
    output in_flit, in_valid, out_ready,
    input  in_ready, out_flit, out_valid, stat_flits
  );

  modport slave (
    input  in_flit, in_valid, out_ready,
    output in_ready, out_flit, out_valid, stat_flits
  );

endinterface

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with full/empty flags; DEPTH must be a power of two >= 2.
// Push while full and pop while empty are ignored.
module noc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count gates every read, so
  // stale entries are never observed and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/noc_xy_router.sv
// Five-port XY dimension-order mesh router with per-input FIFOs, per-output
// round-robin arbitration and registered outputs. Optional macro NOC_STATS_EN.
module noc_xy_router
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int COORD_W    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] my_x,
  input  logic [COORD_W-1:0] my_y,
  noc_xy_router_if.slave     bus
);

  localparam int FLIT_W = DATA_WIDTH + 2 * COORD_W;
  localparam int DX_LSB = dest_x_lsb(DATA_WIDTH);
  localparam int DY_LSB = dest_y_lsb(DATA_WIDTH, COORD_W);

  logic [FLIT_W-1:0]    head       [NUM_PORTS];
  port_t                head_port  [NUM_PORTS];
  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] pop;

  logic [NUM_PORTS-1:0] grant_valid;
  port_t                grant_idx  [NUM_PORTS];
  port_t                sel;

  logic [FLIT_W-1:0]    out_flit_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] out_valid_q;
  port_t                rr_ptr     [NUM_PORTS];

  // Input buffering: the FIFO ignores pushes while full, so no flit is dropped.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    noc_sync_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (bus.in_valid[p]),
      .din   (bus.in_flit[p*FLIT_W +: FLIT_W]),
      .pop   (pop[p]),
      .dout  (head[p]),
      .full  (fifo_full[p]),
      .empty (fifo_empty[p])
    );

    assign head_port[p] = xy_route(COORD_MAX_W'(head[p][DX_LSB +: COORD_W]),
                                   COORD_MAX_W'(head[p][DY_LSB +: COORD_W]),
                                   COORD_MAX_W'(my_x),
                                   COORD_MAX_W'(my_y));
  end

  assign bus.in_ready = ~fifo_full;

  // Each output scans the inputs upward from its pointer; since every head maps
  // to exactly one output, no input can be granted by two outputs at once.
  // NOTE: every signal is given a default first so no path infers a latch.
  always_comb begin
    grant_valid = '0;
    pop         = '0;
    sel         = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      grant_idx[o] = '0;
      if (!out_valid_q[o] || bus.out_ready[o]) begin
        sel = rr_ptr[o];
        for (int k = 0; k < NUM_PORTS; k++) begin
          if (!grant_valid[o] && !fifo_empty[sel] && (head_port[sel] == port_t'(o))) begin
            grant_valid[o] = 1'b1;
            grant_idx[o]   = sel;
          end
          sel = rr_next(sel);
        end
      end
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (grant_valid[o]) pop[grant_idx[o]] = 1'b1;
    end
  end

  // Output registers: a new grant overwrites the slot only when it is empty or
  // being consumed this cycle, so the flit stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_flit_q[o] <= '0;
        rr_ptr[o]     <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (grant_valid[o]) begin
          out_flit_q[o]  <= head[grant_idx[o]];
          out_valid_q[o] <= 1'b1;
          rr_ptr[o]      <= rr_next(grant_idx[o]);
        end else if (bus.out_ready[o]) begin
          out_valid_q[o] <= 1'b0;
        end
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    assign bus.out_flit[o*FLIT_W +: FLIT_W] = out_flit_q[o];
  end
  assign bus.out_valid = out_valid_q;

`ifdef NOC_STATS_EN
  logic [15:0] stat_q [NUM_PORTS];

  // Counts completed output handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_PORTS; o++) stat_q[o] <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (out_valid_q[o] && bus.out_ready[o]) stat_q[o] <= stat_q[o] + 16'd1;
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_stat
    assign bus.stat_flits[o*16 +: 16] = stat_q[o];
  end
`else
  assign bus.stat_flits = '0;
`endif

endmodule

// File: tb/tb_noc_xy_router.sv
// Self-checking bench for noc_xy_router: queue-based reference model compared
// every cycle, plus directed cases with literal expectations.
module tb_noc_xy_router;
  import noc_pkg::*;

  localparam int DW    = 32;
  localparam int CW    = 3;
  localparam int DEPTH = 4;
  localparam int FW    = DW + 2 * CW;

`ifdef NOC_STATS_EN
  localparam bit          STATS_ON = 1'b1;
  localparam int          STAT_RUN = 70000;
  localparam logic [15:0] STAT_EXP = 16'd4464;
`else
  localparam bit          STATS_ON = 1'b0;
  localparam int          STAT_RUN = 3000;
  localparam logic [15:0] STAT_EXP = 16'd0;
`endif

  typedef logic [FW-1:0] flit_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] my_x  = 3'd2;
  logic [CW-1:0] my_y  = 3'd2;

  noc_xy_router_if #(.DATA_WIDTH(DW), .COORD_W(CW)) bus ();

  noc_xy_router #(
    .DATA_WIDTH (DW),
    .COORD_W    (CW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .my_x  (my_x),
    .my_y  (my_y),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  flit_t       mq     [NUM_PORTS][$];
  logic        m_ov   [NUM_PORTS];
  flit_t       m_of   [NUM_PORTS];
  int          m_rr   [NUM_PORTS];
  logic [15:0] m_stat [NUM_PORTS];
  int          m_gsrc [NUM_PORTS];
  logic        m_acc  [NUM_PORTS];

  function automatic int model_route(input flit_t f, input int mx, input int my);
    int dx, dy;
    dx = int'(f[DW +: CW]);
    dy = int'(f[DW+CW +: CW]);
    if (dx > mx) return PORT_E;
    if (dx < mx) return PORT_W;
    if (dy > my) return PORT_S;
    if (dy < my) return PORT_N;
    return PORT_L;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        mq[p].delete();
        m_ov[p]   = 1'b0;
        m_of[p]   = '0;
        m_rr[p]   = 0;
        m_stat[p] = '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (m_ov[o] && bus.out_ready[o]) m_stat[o] = m_stat[o] + 16'd1;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        m_acc[p] = bus.in_valid[p] && (mq[p].size() < DEPTH);
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
        m_gsrc[o] = -1;
        if (!m_ov[o] || bus.out_ready[o]) begin
          for (int k = 0; k < NUM_PORTS; k++) begin
            int i;
            i = (m_rr[o] + k) % NUM_PORTS;
            if (m_gsrc[o] < 0 && mq[i].size() > 0 &&
                model_route(mq[i][0], int'(my_x), int'(my_y)) == o)
              m_gsrc[o] = i;
          end
        end
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (m_gsrc[o] >= 0) begin
          m_of[o] = mq[m_gsrc[o]].pop_front();
          m_ov[o] = 1'b1;
          m_rr[o] = (m_gsrc[o] + 1) % NUM_PORTS;
        end else if (bus.out_ready[o]) begin
          m_ov[o] = 1'b0;
        end
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (m_acc[p]) mq[p].push_back(bus.in_flit[p*FW +: FW]);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [NUM_PORTS-1:0] ev;
    logic [NUM_PORTS-1:0] er;
    for (int o = 0; o < NUM_PORTS; o++) begin
      ev[o] = m_ov[o];
      er[o] = (mq[o].size() < DEPTH);
    end
    check("cyc_out_valid", 64'(bus.out_valid), 64'(ev));
    check("cyc_in_ready", 64'(bus.in_ready), 64'(er));
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (m_ov[o]) check($sformatf("cyc_out_flit%0d", o), 64'(bus.out_flit[o*FW +: FW]), 64'(m_of[o]));
      check($sformatf("cyc_stat%0d", o), 64'(bus.stat_flits[o*16 +: 16]),
            STATS_ON ? 64'(m_stat[o]) : 64'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic flit_t mk(input int dx, input int dy, input logic [31:0] pl);
    return {CW'(dy), CW'(dx), pl};
  endfunction

  task automatic idle();
    bus.in_valid = '0;
    bus.in_flit  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset is asserted away from the negedge so the compare never races it.
  task automatic do_reset();
    idle();
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send1(input int p, input flit_t f);
    bus.in_flit[p*FW +: FW] = f;
    bus.in_valid[p]         = 1'b1;
    step();
    idle();
  endtask

  task automatic route_case(input int dx, input int dy, input logic [4:0] exp_vec, input string name);
    send1(PORT_N, mk(dx, dy, 32'h77));
    step();
    check(name, 64'(bus.out_valid), 64'(exp_vec));
    step();
  endtask

  flit_t got [$];
  int    acc;
  logic  will;

  initial begin
    idle();
    bus.out_ready = '1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_in_ready", 64'(bus.in_ready), 64'h1f);
    check("rst_out_flit", 64'(bus.out_flit[2*FW +: FW]), 64'h0);
    check("rst_stat", 64'(bus.stat_flits), 64'h0);

    // Local -> E latency and identity
    bus.in_flit[0 +: FW] = mk(4, 2, 32'hA5);
    bus.in_valid[0]      = 1'b1;
    step();
    idle();
    check("lat_cycle1_idle", 64'(bus.out_valid), 64'h0);
    step();
    check("lat_cycle2_valid", 64'(bus.out_valid), 64'h04);
    check("lat_flit", 64'(bus.out_flit[2*FW +: FW]), 64'h14_000000A5);
    step();

    // Route decisions from N
    route_case(2, 2, 5'b00001, "route_local");
    route_case(2, 0, 5'b00010, "route_north");
    route_case(1, 5, 5'b10000, "route_west_x_first");

    // Three-way contention on Local
    do_reset();
    bus.in_flit[PORT_N*FW +: FW] = mk(2, 2, 32'h1);
    bus.in_flit[PORT_S*FW +: FW] = mk(2, 2, 32'h3);
    bus.in_flit[PORT_W*FW +: FW] = mk(2, 2, 32'h4);
    bus.in_valid = 5'b11010;
    step();
    idle();
    step();
    check("rr_first_n", 64'(bus.out_flit[0 +: FW]), 64'h12_00000001);
    step();
    check("rr_second_s", 64'(bus.out_flit[0 +: FW]), 64'h12_00000003);
    step();
    check("rr_third_w", 64'(bus.out_flit[0 +: FW]), 64'h12_00000004);
    check("rr_ptr_dut", 64'(dut.rr_ptr[PORT_L]), 64'h0);
    check("rr_ptr_model", 64'(m_rr[PORT_L]), 64'h0);
    step();

    // Backpressure on E: 5 accepted, then stall
    do_reset();
    bus.out_ready[PORT_E] = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      bus.in_flit[0 +: FW] = mk(4, 2, 32'(100 + acc));
      bus.in_valid[0]      = 1'b1;
      will = bus.in_ready[0];
      step();
      if (will) acc++;
    end
    idle();
    check("bp_accepted", 64'(acc), 64'd5);
    check("bp_in_ready_low", 64'(bus.in_ready[0]), 64'h0);
    bus.out_ready[PORT_E] = 1'b1;
    got.delete();
    for (int c = 0; c < 12; c++) begin
      if (bus.out_valid[PORT_E]) got.push_back(bus.out_flit[2*FW +: FW]);
      step();
    end
    check("bp_drained", 64'(got.size()), 64'd5);
    for (int i = 0; i < got.size() && i < 5; i++)
      check($sformatf("bp_order%0d", i), 64'(got[i]), 64'(mk(4, 2, 32'(100 + i))));

    // Reset mid-traffic with flits buffered
    do_reset();
    bus.out_ready[PORT_E] = 1'b0;
    for (int i = 0; i < 4; i++) send1(PORT_L, mk(4, 2, 32'(200 + i)));
    check("mid_pre_valid", 64'(bus.out_valid), 64'h04);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_valid_drop", 64'(bus.out_valid), 64'h0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'h1f);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = '1;
    for (int c = 0; c < 8; c++) begin
      step();
      check("mid_no_stale", 64'(bus.out_valid), 64'h0);
    end

    // Randomized traffic at several router positions
    for (int r = 0; r < 4; r++) begin
      idle();
      #2 rst_n = 1'b0;
      my_x = CW'($urandom_range(7));
      my_y = CW'($urandom_range(7));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 500; c++) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          bus.in_flit[p*FW +: FW] = mk($urandom_range(7), $urandom_range(7), $urandom);
          bus.in_valid[p]         = ($urandom_range(1) == 1);
          bus.out_ready[p]        = ($urandom_range(3) != 0);
        end
        step();
      end
      idle();
      bus.out_ready = '1;
      repeat (40) step();
      check("rand_drained_valid", 64'(bus.out_valid), 64'h0);
      check("rand_drained_ready", 64'(bus.in_ready), 64'h1f);
    end

    // Forwarded-flit counter on E
    my_x = 3'd2;
    my_y = 3'd2;
    do_reset();
    bus.out_ready = '1;
    bus.in_flit[0 +: FW] = mk(4, 2, 32'h5);
    bus.in_valid[0]      = 1'b1;
    repeat (STAT_RUN) step();
    idle();
    repeat (5) step();
    check("stat_e_dut", 64'(bus.stat_flits[2*16 +: 16]), 64'(STAT_EXP));
    check("stat_e_model", 64'(m_stat[PORT_E]), 64'(16'(STAT_RUN)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
